// File: rtl/alu_sequencer.sv
// alu_sequencer: issue-side controller for the tiny16 ALU.
// Latency: a normal instruction takes 5 cycles (IDLE, READ, ISSUE, EXEC, WB).
//          Illegal and divide-by-zero instructions take 3 (IDLE, READ, WB).
// Backpressure: instr_ready is high only in IDLE, so one instruction is in flight.
// Ports:
//   instr_valid/instr_ready/instr     instruction handshake from decode
//   rf_raddr*/rf_rdata*               register file read (combinational data)
//   alu_opcode/alu_ar/alu_src*        registered ALU inputs
//   alu_out_en/alu_out/alu_flags      ALU result, driven on the negedge of EXEC
//   rf_we/rf_waddr/rf_wdata           register file write-back
//   flags                             architectural flags {O,C,N,Z}
//   done/illegal/div0/busy            retire pulses and status
module alu_sequencer #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [RA_W-1:0]   rf_raddr1,
  output logic [RA_W-1:0]   rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [3:0]        alu_opcode,
  output logic              alu_ar,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic              alu_out_en,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flags,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [3:0]        flags,
  output logic              done,
  output logic              illegal,
  output logic              div0,
  output logic              busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;

  // Which kind of retirement WB performs.
  localparam logic [1:0] P_NORM = 2'd0;
  localparam logic [1:0] P_ILL  = 2'd1;
  localparam logic [1:0] P_DIV0 = 2'd2;

  localparam logic [3:0] OP_DIV = 4'b0110;

  logic [2:0]        state_q, state_d;
  logic [15:0]       ir_q, ir_d;
  logic [3:0]        opc_q, opc_d;
  logic              ar_q, ar_d;
  logic [DATA_W-1:0] src1_q, src1_d;
  logic [DATA_W-1:0] src2_q, src2_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [3:0]        flags_q, flags_d;
  logic [1:0]        path_q, path_d;

  logic [3:0] ir_op;
  logic       op_legal;

  assign ir_op    = ir_q[15:12];
  assign op_legal = (ir_op >= 4'b0011) && (ir_op <= 4'b1011);

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    opc_d    = opc_q;
    ar_d     = ar_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    result_d = result_q;
    flags_d  = flags_q;
    path_d   = path_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_READ;
        end
      end
      S_READ: begin
        src1_d = rf_rdata1;
        src2_d = rf_rdata2;
        ar_d   = ir_q[11];
        if (!op_legal) begin
          // Park the ALU on opcode 0 so nothing meaningful is presented.
          opc_d   = 4'b0000;
          path_d  = P_ILL;
          state_d = S_WB;
        end else if (ir_op == OP_DIV && rf_rdata2 == '0) begin
          opc_d    = ir_op;
          path_d   = P_DIV0;
          result_d = {DATA_W{1'b1}};
          state_d  = S_WB;
        end else begin
          opc_d   = ir_op;
          path_d  = P_NORM;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_EXEC;
      S_EXEC: begin
        // alu_out settled at the negedge inside this cycle.
        result_d = alu_out;
        flags_d  = alu_flags;
        state_d  = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      opc_q    <= '0;
      ar_q     <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
      path_q   <= P_NORM;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      opc_q    <= opc_d;
      ar_q     <= ar_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      path_q   <= path_d;
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign rf_raddr1   = (state_q == S_READ) ? ir_q[7:5] : '0;
  assign rf_raddr2   = (state_q == S_READ) ? ir_q[4:2] : '0;
  assign alu_opcode  = opc_q;
  assign alu_ar      = ar_q;
  assign alu_src1    = src1_q;
  assign alu_src2    = src2_q;
  assign alu_out_en  = (state_q == S_EXEC);
  assign done        = (state_q == S_WB);
  assign illegal     = done && (path_q == P_ILL);
  assign div0        = done && (path_q == P_DIV0);
  assign rf_we       = done && (path_q != P_ILL);
  assign rf_waddr    = ir_q[10:8];
  assign rf_wdata    = result_q;
  assign flags       = flags_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue-side controller for the tiny16 datapath ALU. It accepts one 16-bit ALU instruction per handshake, reads both operands from the register file, and drives the ALU's opcode, shift-mode, operand and output-enable inputs. It then captures the ALU result and O/C/N/Z flags, writes the result back to the destination register, and holds the architectural flags register. It sits between the fetch/decode front end and the ALU/register file. It is the initiator for the ALU's posedge-compute / negedge-output protocol.

## Interface
- DATA_W, 16, datapath width; only 16 is supported.
- RA_W, 3, register address width (8 registers).
- clk  in  1  clock; the ALU computes on posedge and drives out/flags on negedge.
- rst  in  1  reset, synchronous, active-high.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  high only in IDLE.
- instr  in  16  fields: [15:12] opcode, [11] ar, [10:8] rd, [7:5] rs1, [4:2] rs2, [1:0] reserved (ignored).
- rf_raddr1 / rf_raddr2  out  RA_W  register file read addresses (rs1, rs2).
- rf_rdata1 / rf_rdata2  in  16  combinational register file read data.
- alu_opcode  out  4  ALU opcode.
- alu_ar  out  1  ALU arithmetic/rotate select.
- alu_src1 / alu_src2  out  16  ALU operands.
- alu_out_en  out  1  ALU output enable.
- alu_out  in  16  ALU result; valid after the negedge of an alu_out_en cycle.
- alu_flags  in  4  ALU flags {O,C,N,Z}.
- rf_we  out  1  register file write strobe.
- rf_waddr  out  RA_W  write address.
- rf_wdata  out  16  write data.
- flags  out  4  architectural flags {O,C,N,Z}.
- done  out  1  1-cycle pulse when an instruction retires.
- illegal  out  1  1-cycle pulse, coincident with done, for a non-ALU opcode.
- div0  out  1  1-cycle pulse, coincident with done, for divide by zero.
- busy  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, READ, ISSUE, EXEC, WB. All outputs are registered or decoded from state only.
- IDLE
  - instr_ready=1.
  - On a posedge with instr_valid=1, latch instr into ir and go to READ.
- READ
  - rf_raddr1=ir[7:5], rf_raddr2=ir[4:2]. These addresses are valid throughout READ and are 0 in other states.
  - At the posedge, latch alu_src1=rf_rdata1, alu_src2=rf_rdata2, alu_opcode=ir[15:12], alu_ar=ir[11].
  - Legal opcodes are 0011..1011. Opcodes 0000..0010 and 1100..1111 are illegal: go to WB with the illegal path flag set, and load alu_opcode=0000.
  - Opcode 0110 with rf_rdata2==0 is divide by zero: go to WB with the div0 path set, and set the result register to 16'hFFFF.
  - Otherwise go to ISSUE.
- ISSUE
  - ALU inputs are held stable; the ALU evaluates on the posedge that ends ISSUE.
  - Next state is EXEC.
- EXEC
  - alu_out_en=1; the ALU drives alu_out/alu_flags at the mid-cycle negedge.
  - At the posedge, capture result=alu_out and flags=alu_flags.
  - Next state is WB.
- WB
  - done=1.
  - Normal path: rf_we=1, rf_waddr=ir[10:8], rf_wdata=result.
  - Illegal path: rf_we=0, illegal=1, flags unchanged.
  - div0 path: rf_we=1, rf_wdata=16'hFFFF, div0=1, flags unchanged.
  - Next state is IDLE.
- alu_out_en=0 in every state except EXEC; alu_out is never sampled outside EXEC.
- ALU inputs keep their last value after an instruction, and clear only on reset.
- rd equal to rs1 or rs2 is legal. Operands are read in READ, before the write in WB, so no hazard exists.
- Reset (any state, including mid-EXEC):
  - Next edge: state=IDLE.
  - Outputs: instr_ready=1, rf_we=0, done=0, illegal=0, div0=0, busy=0, alu_out_en=0.
  - Registers: alu_opcode=0, alu_ar=0, alu_src1=0, alu_src2=0, flags=0, rf_waddr=0, rf_wdata=0, result=0, ir=0.
  - The in-flight instruction is dropped with no write.

## Timing
- Accept edge T0 (end of IDLE). READ is cycle 1, ISSUE cycle 2, EXEC cycle 3, WB cycle 4; IDLE again in cycle 5.
- Illegal and div0 instructions skip ISSUE and EXEC: WB is cycle 2.
- Throughput: one normal instruction per 5 cycles; an illegal or div0 instruction takes 3 cycles.
- instr_valid held high back-to-back: the next instruction is accepted at the end of the IDLE cycle following WB.
- The flags output changes at the posedge ending EXEC, i.e. visible during WB.
- rf_we is high for exactly one cycle per retired legal or div0 instruction.

## Test plan
- Reset, then ADD (0011) r3=r1+r2 with r1=16'h7FFF, r2=16'h0001.
  - Expect: r3=16'h8000 written in cycle 4.
  - Expect: flags=4'b1010 (O=1, N=1), visible in WB.
- SUB (0100) r2=r1-r1 with r1=16'h0005.
  - Expect: rf_wdata=0 and flags Z=1.
  - Expect: rf_raddr1 and rf_raddr2 both 1 during READ.
- Opcode 1110.
  - Expect: done and illegal pulse in cycle 2, rf_we=0, alu_out_en never high.
  - Expect: flags equal their prior value.
- DIV (0110) with r2=0.
  - Expect: rd written 16'hFFFF in cycle 2, div0 pulse, flags unchanged, no EXEC cycle.
- Assert rst during EXEC of a valid ADD.
  - Expect next cycle: IDLE, rf_we=0, flags=0, busy=0; no write ever occurs for that instruction.
- instr_valid held high with 3 queued ADDs.
  - Expect: accepts at cycles 0, 5 and 10; three rf_we pulses at cycles 4, 9 and 14.
